// File: rtl/vector_adder_pkg.sv
// Shared constants and types for the segmented 64-bit vector add/subtract stage.
package vector_adder_pkg;

  localparam int SLICE_W = 8;
  localparam int SLICE_N = 8;
  localparam int DATA_W  = SLICE_W * SLICE_N;

  localparam logic [1:0] SEL_INTERCONNECT = 2'b00;
  localparam logic [1:0] SEL_ADD          = 2'b01;
  localparam logic [1:0] SEL_SUB          = 2'b10;
  localparam logic [1:0] SEL_EXT_CARRY    = 2'b11;

  localparam logic [1:0] SEW_8  = 2'b00;
  localparam logic [1:0] SEW_16 = 2'b01;
  localparam logic [1:0] SEW_32 = 2'b10;
  localparam logic [1:0] SEW_64 = 2'b11;

  typedef struct packed {
    logic                   add_sub;
    logic [1:0]             vsew;
    logic [2*SLICE_N-1:0]   sel;
    logic [DATA_W-1:0]      op_a;
    logic [DATA_W-1:0]      op_b;
    logic [SLICE_N-1:0]     carry_mask;
  } beat_t;

  // Picks each element's top-slice carry; borrow is the inverted carry on subtract.
  function automatic logic [SLICE_N-1:0] gather_carry(input logic [SLICE_N-1:0] cout,
                                                      input logic [1:0] vsew,
                                                      input logic add_sub);
    logic [SLICE_N-1:0] c;
    logic [SLICE_N-1:0] g;
    c = cout ^ {SLICE_N{add_sub}};
    g = '0;
    case (vsew)
      SEW_8:   g = c;
      SEW_16:  for (int e = 0; e < 4; e++) g[e] = c[2*e+1];
      SEW_32:  begin g[0] = c[3]; g[1] = c[7]; end
      default: g[0] = c[7];
    endcase
    return g;
  endfunction

endpackage

// File: rtl/vector_adder_if.sv
// Operand/result bus of the vector adder stage; slave = datapath view, master = driver view.
interface vector_adder_if;
  import vector_adder_pkg::*;

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic                 add_sub_i;
  logic [1:0]           vsew_i;
  logic [2*SLICE_N-1:0] sel_i;
  logic [DATA_W-1:0]    op_a_i;
  logic [DATA_W-1:0]    op_b_i;
  logic [SLICE_N-1:0]   carry_mask_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [DATA_W-1:0]    result_o;
  logic [SLICE_N-1:0]   carry_o;

  modport slave (
    input  in_valid_i, add_sub_i, vsew_i, sel_i, op_a_i, op_b_i, carry_mask_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, carry_o
  );

  modport master (
    output in_valid_i, add_sub_i, vsew_i, sel_i, op_a_i, op_b_i, carry_mask_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, carry_o
  );

endinterface

// File: rtl/vector_adder_slice.sv
// One 8-bit adder slice whose carry-in comes from a 2-bit carry-select code (combinational).
module adder_slice
  import vector_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               add_sub,
  input  logic [1:0]         sel,
  input  logic               cin_chain,
  input  logic               ext_bit,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W-1:0] b_eff;
  logic               cin;

  always_comb begin
    b_eff = add_sub ? ~b : b;
    cin   = 1'b0;
    case (sel)
      SEL_INTERCONNECT: cin = cin_chain;
      SEL_ADD:          cin = 1'b0;
      SEL_SUB:          cin = 1'b1;
      default:          cin = ext_bit ^ add_sub;
    endcase
    {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, cin};
  end

endmodule

// File: rtl/vector_adder_stage.sv
// Two-stage segmented vector add/subtract: beat accepted at edge t is valid after edge t+1.
// Both stages advance only when the output is empty or being taken, so a stall freezes everything.
module vector_adder_stage
  import vector_adder_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  vector_adder_if.slave  bus
);

  logic                 en;
  logic                 s1_valid_q, s1_valid_d;
  beat_t                s1_q, s1_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic [SLICE_N-1:0]   carry_q, carry_d;

  logic [DATA_W-1:0]    sum;
  logic [SLICE_N-1:0]   cout;
  logic [SLICE_N-1:0]   cin_chain;
  logic [SLICE_N-1:0]   ext_bit;

  assign en              = ~out_valid_q | bus.out_ready_i;
  assign bus.in_ready_o  = en;
  assign bus.out_valid_o = out_valid_q;
  assign bus.result_o    = result_q;
  assign bus.carry_o     = carry_q;

  assign cin_chain = {cout[SLICE_N-2:0], 1'b0};

  // Slice k belongs to element k >> vsew, which selects its v0 mask bit.
  always_comb begin
    ext_bit = '0;
    for (int k = 0; k < SLICE_N; k++) begin
      ext_bit[k] = s1_q.carry_mask[3'(k) >> s1_q.vsew];
    end
  end

  for (genvar k = 0; k < SLICE_N; k++) begin : g_slice
    adder_slice u_slice (
      .a         (s1_q.op_a[k*SLICE_W +: SLICE_W]),
      .b         (s1_q.op_b[k*SLICE_W +: SLICE_W]),
      .add_sub   (s1_q.add_sub),
      .sel       (s1_q.sel[2*k +: 2]),
      .cin_chain (cin_chain[k]),
      .ext_bit   (ext_bit[k]),
      .sum       (sum[k*SLICE_W +: SLICE_W]),
      .cout      (cout[k])
    );
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    if (en) begin
      s1_valid_d       = bus.in_valid_i;
      s1_d.add_sub     = bus.add_sub_i;
      s1_d.vsew        = bus.vsew_i;
      s1_d.sel         = bus.sel_i;
      s1_d.op_a        = bus.op_a_i;
      s1_d.op_b        = bus.op_b_i;
      s1_d.carry_mask  = bus.carry_mask_i;
      out_valid_d      = s1_valid_q;
      result_d         = sum;
      carry_d          = gather_carry(cout, s1_q.vsew, s1_q.add_sub);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
    end
  end

endmodule
